// File: rtl/cordic_pkg.sv
// Shared types and default widths for the CORDIC iteration sequencer.
// Holds the run/idle state type used by cordic_iter_counter.
package cordic_pkg;
   localparam int CORDIC_ITER_W  = 6;
   localparam int CORDIC_PRESC_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } cnt_state_t;
endpackage

// File: rtl/cordic_prescaler.sv
// Step prescaler: counts 0..presc_val while enabled, strobing del on the
// last count. Ports: clk, rst (async high), en, clr, presc_val, del.
module cordic_prescaler
   import cordic_pkg::*;
#(
   parameter int PRESC_W = CORDIC_PRESC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr,
   input  logic [PRESC_W-1:0] presc_val,
   output logic               del
);
   logic [PRESC_W-1:0] cnt_q;
   logic [PRESC_W-1:0] cnt_d;

   // Decoded only from registered count and latched prescale.
   assign del = en && (cnt_q == presc_val);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = del ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/cordic_iter_counter.sv
// Modulo iteration counter with prescaler and start/busy/done handshake.
// Ports: clk, rst (async high), start, clr, mod_val, presc_val -> q, del,
// tc, busy, done. Define CORDIC_CNT_WRAP_EN to add the cont input
// (continuous wrap mode, latched on start).
module cordic_iter_counter
   import cordic_pkg::*;
#(
   parameter int WIDTH   = CORDIC_ITER_W,
   parameter int PRESC_W = CORDIC_PRESC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               clr,
`ifdef CORDIC_CNT_WRAP_EN
   input  logic               cont,
`endif
   input  logic [WIDTH-1:0]   mod_val,
   input  logic [PRESC_W-1:0] presc_val,
   output logic [WIDTH-1:0]   q,
   output logic               del,
   output logic               tc,
   output logic               busy,
   output logic               done
);
   cnt_state_t         state_q, state_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   mod_q, mod_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               done_q, done_d;
   logic               run;
   logic               wrap;
   logic [WIDTH-1:0]   last;

`ifdef CORDIC_CNT_WRAP_EN
   logic cont_q, cont_d;
   assign wrap = cont_q;
`else
   assign wrap = 1'b0;
`endif

   assign run  = (state_q == RUN);
   // Modulus 0 wraps to all-ones, i.e. 2^WIDTH steps.
   assign last = mod_q - 1'b1;

   cordic_prescaler #(
      .PRESC_W   (PRESC_W)
   ) u_presc (
      .clk       (clk),
      .rst       (rst),
      .en        (run),
      .clr       (clr || !run),
      .presc_val (presc_q),
      .del       (del)
   );

   assign tc   = del && (q_q == last);
   assign q    = q_q;
   assign busy = run;
   assign done = done_q;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      mod_d   = mod_q;
      presc_d = presc_q;
      done_d  = 1'b0;
`ifdef CORDIC_CNT_WRAP_EN
      cont_d  = cont_q;
`endif
      if (clr) begin
         state_d = IDLE;
         q_d     = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = RUN;
                  q_d     = '0;
                  mod_d   = mod_val;
                  presc_d = presc_val;
`ifdef CORDIC_CNT_WRAP_EN
                  cont_d  = cont;
`endif
               end
            end
            RUN: begin
               if (del) begin
                  if (tc && !wrap) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else if (tc) begin
                     q_d = '0;
                  end else begin
                     q_d = q_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         q_q     <= '0;
         mod_q   <= '0;
         presc_q <= '0;
         done_q  <= 1'b0;
`ifdef CORDIC_CNT_WRAP_EN
         cont_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         mod_q   <= mod_d;
         presc_q <= presc_d;
         done_q  <= done_d;
`ifdef CORDIC_CNT_WRAP_EN
         cont_q  <= cont_d;
`endif
      end
   end
endmodule

// File: tb/tb_cordic_iter_counter.sv
// Self-checking bench for cordic_iter_counter: vector table, corner
// sequences and a randomized run against a timing-arithmetic model.
module tb_cordic_iter_counter;
   localparam int W  = 6;
   localparam int PW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          clr;
`ifdef CORDIC_CNT_WRAP_EN
   logic          cont;
`endif
   logic [W-1:0]  mod_val;
   logic [PW-1:0] presc_val;
   logic [W-1:0]  q;
   logic          del, tc, busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cordic_iter_counter #(
      .WIDTH     (W),
      .PRESC_W   (PW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .clr       (clr),
`ifdef CORDIC_CNT_WRAP_EN
      .cont      (cont),
`endif
      .mod_val   (mod_val),
      .presc_val (presc_val),
      .q         (q),
      .del       (del),
      .tc        (tc),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int mv;
      int pv;
      int len;
      int steps;
      int lastq;
   } vec_t;

   vec_t tbl[7];

   // Starts a run and counts busy/del/tc cycles until done (bounded).
   task automatic run_one(input int mv, input int pv,
                          output int bcyc, output int dels,
                          output int tcs, output int qdone,
                          output int dbusy, output int dseen);
      bcyc = 0; dels = 0; tcs = 0; qdone = -1; dbusy = -1; dseen = 0;
      @(negedge clk);
      start     = 1'b1;
      mod_val   = mv[W-1:0];
      presc_val = pv[PW-1:0];
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (done) begin
            dseen = 1;
            qdone = int'(q);
            dbusy = int'(busy);
            break;
         end
         if (busy) bcyc++;
         if (del)  dels++;
         if (tc)   tcs++;
         @(negedge clk);
      end
   endtask

   int bc, dl, tcn, qd, db, ds;
   int seen;
   int m_run, m_t, m_M, m_P, m_qi, m_done;
   int k, step, ph, eq, edel, etc, ebusy, edone;
   int s, cl, mv, pv;

   initial begin
      tbl[0] = '{6, 0,   6,  6,  5};
      tbl[1] = '{6, 1,  12,  6,  5};
      tbl[2] = '{0, 0,  64, 64, 63};
      tbl[3] = '{1, 0,   1,  1,  0};
      tbl[4] = '{1, 3,   4,  1,  0};
      tbl[5] = '{3, 7,  24,  3,  2};
      tbl[6] = '{0, 2, 192, 64, 63};

      rst = 1'b1; start = 1'b0; clr = 1'b0;
      mod_val = '0; presc_val = '0;
`ifdef CORDIC_CNT_WRAP_EN
      cont = 1'b0;
`endif
      #3;
      check("rst_q", int'(q), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_del", int'(del), 0);
      check("rst_tc", int'(tc), 0);
      check("rst_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven runs.
      for (int i = 0; i < 7; i++) begin
         run_one(tbl[i].mv, tbl[i].pv, bc, dl, tcn, qd, db, ds);
         check($sformatf("tbl%0d_done", i), ds, 1);
         check($sformatf("tbl%0d_len", i), bc, tbl[i].len);
         check($sformatf("tbl%0d_steps", i), dl, tbl[i].steps);
         check($sformatf("tbl%0d_tc", i), tcn, 1);
         check($sformatf("tbl%0d_qdone", i), qd, tbl[i].lastq);
         check($sformatf("tbl%0d_dbusy", i), db, 0);
      end

      // q sequence 0..5, done, then back-to-back start in done cycle.
      @(negedge clk);
      start = 1'b1; mod_val = 6'd6; presc_val = 3'd0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("seq_q%0d", i), int'(q), i);
         check($sformatf("seq_tc%0d", i), int'(tc), (i == 5) ? 1 : 0);
         check($sformatf("seq_busy%0d", i), int'(busy), 1);
         @(negedge clk);
      end
      check("seq_done", int'(done), 1);
      check("seq_done_busy", int'(busy), 0);
      check("seq_hold_q", int'(q), 5);
      start = 1'b1; mod_val = 6'd2;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", int'(busy), 1);
      check("b2b_q", int'(q), 0);
      check("b2b_done", int'(done), 0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin seen = 1; break; end
         @(negedge clk);
      end
      check("b2b_finish", seen, 1);

      // clr on the terminal step wins over done and start.
      @(negedge clk);
      start = 1'b1; mod_val = 6'd6; presc_val = 3'd0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) @(negedge clk);
      check("clr_pre_tc", int'(tc), 1);
      clr = 1'b1; start = 1'b1;
      @(negedge clk);
      clr = 1'b0; start = 1'b0;
      check("clr_busy", int'(busy), 0);
      check("clr_q", int'(q), 0);
      check("clr_done", int'(done), 0);
      @(negedge clk);
      check("clr_done2", int'(done), 0);
      check("clr_busy2", int'(busy), 0);

      // start during RUN is ignored.
      @(negedge clk);
      start = 1'b1; mod_val = 6'd4; presc_val = 3'd1;
      @(negedge clk);
      start = 1'b0;
      bc = 0; seen = 0;
      for (int i = 0; i < 50; i++) begin
         if (done) begin seen = 1; qd = int'(q); break; end
         if (busy) bc++;
         start = (i == 2 || i == 3) ? 1'b1 : 1'b0;
         mod_val = 6'd10; presc_val = 3'd0;
         @(negedge clk);
      end
      start = 1'b0;
      check("ign_done", seen, 1);
      check("ign_len", bc, 8);
      check("ign_q", qd, 3);

      // Asynchronous reset mid-run at q==3.
      @(negedge clk);
      start = 1'b1; mod_val = 6'd8; presc_val = 3'd1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         if (q == 6'd3) begin seen = 1; break; end
         @(negedge clk);
      end
      check("arst_reach_q3", seen, 1);
      rst = 1'b1;
      #1;
      check("arst_q", int'(q), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_del", int'(del), 0);
      check("arst_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      run_one(5, 0, bc, dl, tcn, qd, db, ds);
      check("arst_rerun_done", ds, 1);
      check("arst_rerun_len", bc, 5);
      check("arst_rerun_q", qd, 4);

`ifdef CORDIC_CNT_WRAP_EN
      // Continuous mode wraps and never signals done.
      @(negedge clk);
      start = 1'b1; cont = 1'b1; mod_val = 6'd4; presc_val = 3'd0;
      @(negedge clk);
      start = 1'b0; cont = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("wrap_q%0d", i), int'(q), i % 4);
         check($sformatf("wrap_tc%0d", i), int'(tc), (i % 4 == 3) ? 1 : 0);
         check($sformatf("wrap_done%0d", i), int'(done), 0);
         check($sformatf("wrap_busy%0d", i), int'(busy), 1);
         @(negedge clk);
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("wrap_clr_busy", int'(busy), 0);
      check("wrap_clr_q", int'(q), 0);
      check("wrap_clr_done", int'(done), 0);
`endif

      // Randomized traffic against the timing model.
      @(negedge clk);
      rst = 1'b1; start = 1'b0; clr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_run = 0; m_t = 0; m_M = 1; m_P = 0; m_qi = 0; m_done = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (m_run != 0) begin
            k     = m_t - 1;
            step  = k / (m_P + 1);
            ph    = k % (m_P + 1);
            eq    = step;
            edel  = (ph == m_P) ? 1 : 0;
            etc   = (edel != 0 && step == m_M - 1) ? 1 : 0;
            ebusy = 1;
            edone = 0;
         end else begin
            eq = m_qi; edel = 0; etc = 0; ebusy = 0; edone = m_done;
         end
         check("rnd_q", int'(q), eq);
         check("rnd_del", int'(del), edel);
         check("rnd_tc", int'(tc), etc);
         check("rnd_busy", int'(busy), ebusy);
         check("rnd_done", int'(done), edone);

         s  = ($urandom_range(0, 2) == 0) ? 1 : 0;
         cl = ($urandom_range(0, 63) == 0) ? 1 : 0;
         mv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
         pv = int'($urandom_range(0, 3));
         start     = s[0];
         clr       = cl[0];
         mod_val   = mv[W-1:0];
         presc_val = pv[PW-1:0];

         if (cl != 0) begin
            m_run = 0; m_qi = 0; m_done = 0;
         end else if (m_run != 0) begin
            m_done = 0;
            if (etc != 0) begin
               m_run = 0; m_qi = m_M - 1; m_done = 1;
            end else begin
               m_t++;
            end
         end else begin
            m_done = 0;
            if (s != 0) begin
               m_run = 1; m_t = 1;
               m_M = (mv == 0) ? 64 : mv;
               m_P = pv;
            end
         end
      end
      @(negedge clk);
      start = 1'b0; clr = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
